// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down counter with load/start/pause control and a done pulse at 00.
// WRAP selects stop-at-zero or reload-from-preset behaviour.
module bcd_countdown_timer #(
  parameter bit         WRAP     = 1'b0,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [7:0] q,
  output logic       run,
  output logic       zero,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] preset_q, preset_d;
  logic       done_q, done_d;
  logic [7:0] load_san;
  logic [7:0] q_dec;

  // Out-of-range digits clamp to 9 so the count stays valid BCD.
  always_comb begin
    load_san[7:4] = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    load_san[3:0] = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
  end

  always_comb begin
    if (q_q[3:0] != 4'd0) begin
      q_dec = {q_q[7:4], q_q[3:0] - 4'd1};
    end else begin
      q_dec = {q_q[7:4] - 4'd1, 4'd9};
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (load) begin
      preset_d = load_san;
      q_d      = load_san;
      state_d  = StIdle;
    end else if (pause) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else if (start && (state_q == StIdle || state_q == StPause) && q_q != 8'h00) begin
      state_d = StRun;
    end else if (tick && state_q == StRun) begin
      if (q_q == 8'h01) begin
        done_d = 1'b1;
        if (WRAP && preset_q != 8'h00) begin
          q_d = preset_q;
        end else begin
          q_d     = 8'h00;
          state_d = StDone;
        end
      end else if (q_q != 8'h00) begin
        q_d = q_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      q_q      <= INIT_VAL;
      preset_q <= INIT_VAL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  assign q    = q_q;
  assign run  = (state_q == StRun);
  assign zero = (q_q == 8'h00);
  assign done = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: one stop-at-zero instance and one wrapping instance share the stimulus.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, tick;
  logic [7:0] load_val;
  logic [7:0] q0, q1;
  logic       run0, run1, zero0, zero1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.WRAP(1'b0), .INIT_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .q(q0), .run(run0), .zero(zero0), .done(done0)
  );

  bcd_countdown_timer #(.WRAP(1'b1), .INIT_VAL(8'h25)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .q(q1), .run(run1), .zero(zero1), .done(done1)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic ld, input logic [7:0] lv,
                     input logic st, input logic pa, input logic tk);
    rst = r; load = ld; load_val = lv; start = st; pause = pa; tick = tk;
    @(posedge clk);
    #1;
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0; tick = 1'b0;
    #2;

    // Reset
    cyc(1, 0, 8'h00, 0, 0, 0);
    check_val("rst_q0", q0, 8'h00);
    check_val("rst_zero0", {7'd0, zero0}, 8'd1);
    check_val("rst_run0", {7'd0, run0}, 8'd0);
    check_val("rst_done0", {7'd0, done0}, 8'd0);
    check_val("rst_q1", q1, 8'h25);
    check_val("rst_zero1", {7'd0, zero1}, 8'd0);

    // Count 12 -> 09 across a tens borrow
    cyc(0, 1, 8'h12, 0, 0, 0);
    check_val("ld12_q", q0, 8'h12);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check_val("st12_run", {7'd0, run0}, 8'd1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("t1_q", q0, 8'h11);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("t2_q", q0, 8'h10);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("t3_q", q0, 8'h09);
    check_val("t3_run", {7'd0, run0}, 8'd1);

    // Terminal count with WRAP=0
    cyc(0, 1, 8'h02, 0, 0, 0);
    check_val("ld02_run", {7'd0, run0}, 8'd0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("d1_q", q0, 8'h01);
    check_val("d1_done", {7'd0, done0}, 8'd0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("d0_q", q0, 8'h00);
    check_val("d0_done", {7'd0, done0}, 8'd1);
    check_val("d0_zero", {7'd0, zero0}, 8'd1);
    check_val("d0_run", {7'd0, run0}, 8'd0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("dpost_done", {7'd0, done0}, 8'd0);
    check_val("dpost_q", q0, 8'h00);
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("dstart_run", {7'd0, run0}, 8'd0);
    check_val("dstart_q", q0, 8'h00);

    // Sanitising load values
    cyc(0, 1, 8'hAF, 0, 0, 0);
    check_val("san_AF", q0, 8'h99);
    cyc(0, 1, 8'h5C, 0, 0, 0);
    check_val("san_5C", q0, 8'h59);

    // Pause behaviour
    cyc(0, 1, 8'h30, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check_val("p_run", {7'd0, run0}, 8'd1);
    cyc(0, 0, 8'h00, 0, 1, 1);
    check_val("p_tick_q", q0, 8'h30);
    check_val("p_tick_run", {7'd0, run0}, 8'd0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("p_hold_q", q0, 8'h30);
    cyc(0, 0, 8'h00, 1, 1, 0);
    check_val("p_startpause", {7'd0, run0}, 8'd0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check_val("p_resume", {7'd0, run0}, 8'd1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("p_tick29", q0, 8'h29);
    cyc(0, 0, 8'h00, 1, 1, 0);
    check_val("p_sp_run", {7'd0, run0}, 8'd0);

    // Start at 00 is ignored
    cyc(0, 1, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check_val("z_start_run", {7'd0, run0}, 8'd0);

    // WRAP=1 reload
    cyc(0, 1, 8'h01, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_val("w_q", q1, 8'h01);
    check_val("w_done", {7'd0, done1}, 8'd1);
    check_val("w_run", {7'd0, run1}, 8'd1);
    cyc(0, 0, 8'h00, 0, 0, 0);
    check_val("w_done_off", {7'd0, done1}, 8'd0);
    check_val("w_run_hold", {7'd0, run1}, 8'd1);
    cyc(1, 0, 8'h00, 0, 0, 1);
    check_val("w_rst_q", q1, 8'h25);
    check_val("w_rst_run", {7'd0, run1}, 8'd0);
    check_val("w_rst_done", {7'd0, done1}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
